// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction bus and fills the IF/ID register.
// Redirects from the exception unit and ID are merged into a single target with fixed priority.
module if_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_stall_i,
  input  logic        if_flush_i,
  input  logic        take_branch_i,
  input  logic [31:0] pc_branch_address_i,
  input  logic        jump_i,
  input  logic [31:0] pc_jump_address_i,
  input  logic        exc_trap_i,
  input  logic [31:0] exc_pc_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_add4_o,
  output logic [31:0] id_instruction_o,
  output logic        id_exc_address_if_o,
  output logic        id_exc_access_if_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    IFID_KEEP,
    IFID_BUBBLE,
    IFID_FETCH,
    IFID_BUF,
    IFID_MISALIGN
  } ifid_sel_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending;
  logic        r_active;
  logic [31:0] r_buf_data;
  logic        r_buf_err;

  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_add4;
  logic [31:0] r_id_instr;
  logic        r_id_exc_addr;
  logic        r_id_exc_acc;

  logic        w_misaligned;
  logic        w_stb;
  logic        w_resp;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_add4;
  logic [31:0] w_pc_next;
  logic        w_pending_load;
  logic        w_buf_load;
  ifid_sel_t   w_ifid_sel;

  // r_active keeps the strobe low while reset is held and for the edge that releases it.
  assign w_misaligned = |r_pc[1:0];
  assign w_stb        = r_active && (r_state != S_HOLD) && !w_misaligned;
  assign w_resp       = w_stb && (iport_ack_i || iport_err_i);
  assign w_redirect   = exc_trap_i || (!if_stall_i && (take_branch_i || jump_i));
  assign w_pc_add4    = r_pc + 32'd4;

  always_comb begin
    if (exc_trap_i) begin
      w_target = exc_pc_i;
    end else if (take_branch_i) begin
      w_target = pc_branch_address_i;
    end else begin
      w_target = pc_jump_address_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_REQ: begin
        if (w_resp && !w_redirect && if_stall_i) begin
          w_next_state = S_HOLD;
        end else if (w_stb && !w_resp && w_redirect) begin
          w_next_state = S_KILL;
        end
      end
      S_HOLD: begin
        if (w_redirect || !if_stall_i) begin
          w_next_state = S_REQ;
        end
      end
      S_KILL: begin
        if (w_resp) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_REQ;
    endcase
  end

  always_comb begin
    w_pc_next      = r_pc;
    w_pending_load = 1'b0;
    w_buf_load     = 1'b0;
    w_ifid_sel     = IFID_BUBBLE;
    unique case (r_state)
      S_REQ: begin
        if (!w_stb) begin
          if (w_redirect) begin
            w_pc_next = w_target;
          end else if (r_active && w_misaligned) begin
            w_ifid_sel = IFID_MISALIGN;
          end
        end else if (w_resp) begin
          if (w_redirect) begin
            w_pc_next = w_target;
          end else if (!if_stall_i) begin
            w_pc_next  = w_pc_add4;
            w_ifid_sel = IFID_FETCH;
          end else begin
            w_buf_load = 1'b1;
          end
        end else if (w_redirect) begin
          w_pending_load = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_next = w_target;
        end else if (!if_stall_i) begin
          w_pc_next  = w_pc_add4;
          w_ifid_sel = IFID_BUF;
        end
      end
      S_KILL: begin
        // The outstanding response is stale; a newer redirect replaces the pending target.
        if (w_redirect) begin
          if (w_resp) begin
            w_pc_next = w_target;
          end else begin
            w_pending_load = 1'b1;
          end
        end else if (w_resp) begin
          w_pc_next = r_pending;
        end
      end
      default: ;
    endcase
    if (if_flush_i) begin
      w_ifid_sel = IFID_BUBBLE;
    end else if (if_stall_i) begin
      w_ifid_sel = IFID_KEEP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc      <= RESET_ADDR;
      r_pending <= RESET_ADDR;
      r_active  <= 1'b0;
      r_buf_err <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_active <= 1'b1;
      if (w_pending_load) begin
        r_pending <= w_target;
      end
      if (w_buf_load) begin
        r_buf_err <= iport_err_i;
      end
    end
  end

  // NOTE: the buffered word is datapath only and is always written before HOLD reads it, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (w_buf_load) begin
      r_buf_data <= iport_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_id_pc       <= RESET_ADDR;
      r_id_pc_add4  <= RESET_ADDR + 32'd4;
      r_id_instr    <= NOP_INSTR;
      r_id_exc_addr <= 1'b0;
      r_id_exc_acc  <= 1'b0;
    end else begin
      unique case (w_ifid_sel)
        IFID_KEEP: ;
        IFID_BUBBLE: begin
          // Bubbles keep the PC so a flushed slot still reports where it was.
          r_id_instr    <= NOP_INSTR;
          r_id_exc_addr <= 1'b0;
          r_id_exc_acc  <= 1'b0;
        end
        IFID_FETCH: begin
          r_id_pc       <= r_pc;
          r_id_pc_add4  <= w_pc_add4;
          r_id_instr    <= iport_data_i;
          r_id_exc_addr <= 1'b0;
          r_id_exc_acc  <= iport_err_i;
        end
        IFID_BUF: begin
          r_id_pc       <= r_pc;
          r_id_pc_add4  <= w_pc_add4;
          r_id_instr    <= r_buf_data;
          r_id_exc_addr <= 1'b0;
          r_id_exc_acc  <= r_buf_err;
        end
        IFID_MISALIGN: begin
          r_id_pc       <= r_pc;
          r_id_pc_add4  <= w_pc_add4;
          r_id_instr    <= NOP_INSTR;
          r_id_exc_addr <= 1'b1;
          r_id_exc_acc  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign iport_addr_o        = r_pc;
  assign iport_stb_o         = w_stb;
  assign id_pc_o             = r_id_pc;
  assign id_pc_add4_o        = r_id_pc_add4;
  assign id_instruction_o    = r_id_instr;
  assign id_exc_address_if_o = r_id_exc_addr;
  assign id_exc_access_if_o  = r_id_exc_acc;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, the bubble instruction (addi x0,x0,0).
REQ-003 clk_i  in  1  the single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 if_stall_i  in  1  hazard unit stall: hold the IF/ID register and the PC.
REQ-006 if_flush_i  in  1  load a bubble into the IF/ID register.
REQ-007 take_branch_i  in  1  the ID stage resolved a taken branch.
REQ-008 pc_branch_address_i  in  32  branch target from ID.
REQ-009 jump_i  in  1  the ID stage holds a jal/jalr.
REQ-010 pc_jump_address_i  in  32  jump target from ID.
REQ-011 exc_trap_i  in  1  trap redirect from the exception unit.
REQ-012 exc_pc_i  in  32  trap vector.
REQ-013 iport_addr_o  out  32  instruction bus address.
REQ-014 iport_stb_o  out  1  bus request strobe.
REQ-015 iport_data_i  in  32  fetched word.
REQ-016 iport_ack_i  in  1  bus completion.
REQ-017 iport_err_i  in  1  bus error completion.
REQ-018 id_pc_o  out  32  PC of the instruction in ID.
REQ-019 id_pc_add4_o  out  32  id_pc_o + 4.
REQ-020 id_instruction_o  out  32  instruction in ID.
REQ-021 id_exc_address_if_o  out  1  misaligned fetch address.
REQ-022 id_exc_access_if_o  out  1  fetch bus error.

Function
REQ-023 The next PC SHALL be selected by priority: exc_trap_i > take_branch_i > jump_i > pc+4, where the +4 add wraps modulo 2^32.
REQ-024 exc_trap_i SHALL be honoured in every cycle; branch and jump redirects SHALL be honoured only while if_stall_i=0.
REQ-025 The FSM states SHALL be REQ (strobe high), HOLD (word buffered, strobe low) and KILL (strobe high, current response is to be discarded).
REQ-026 iport_addr_o SHALL equal the PC register, and the PC SHALL stay unchanged while iport_stb_o=1 and no ack or err has arrived.
REQ-027 In REQ, on ack or err with if_stall_i=0, the IF/ID register SHALL capture {pc, pc+4, data, 0, err} and the PC SHALL advance at the same edge; with zero-wait memory this gives one instruction per cycle.
REQ-028 In REQ, on ack or err with if_stall_i=1, the word and its error bit SHALL be buffered and the FSM SHALL enter HOLD.
REQ-029 In HOLD, when if_stall_i falls, the IF/ID register SHALL load the buffer, the PC SHALL advance and the FSM SHALL enter REQ.
REQ-030 A redirect while a request is outstanding without ack SHALL latch the target into a pending register and enter KILL.
REQ-031 In KILL, the arriving response SHALL be discarded, the PC SHALL load the pending target, and the FSM SHALL enter REQ.
REQ-032 A redirect in the same cycle as ack SHALL discard the data and load the target directly into the PC.
REQ-033 A redirect in HOLD SHALL drop the buffer and enter REQ at the target.
REQ-034 If pc[1:0]!=0, the block SHALL not assert the strobe; the IF/ID register SHALL load NOP_INSTR with id_exc_address_if_o=1, and the FSM SHALL wait for a redirect.
REQ-035 On any cycle with if_stall_i=0 and no instruction delivered (wait, discard or redirect), the IF/ID register SHALL load NOP_INSTR with both exception flags 0.
REQ-036 if_flush_i SHALL override if_stall_i and load a bubble, while keeping id_pc_o.

Reset
REQ-037 While rst_i=0, the block SHALL force: PC=RESET_ADDR, state=REQ, iport_stb_o=0, id_instruction_o=NOP_INSTR, id_pc_o=RESET_ADDR, id_pc_add4_o=RESET_ADDR+4, and both exception flags 0.
REQ-038 An assertion of rst_i during an outstanding request SHALL drop the strobe immediately, and the late ack SHALL be ignored.
REQ-039 iport_stb_o SHALL rise in the first cycle after rst_i deasserts.

Verification
REQ-040 Zero-wait ack and words 0x11,0x22,0x33 -> addresses 0,4,8 on consecutive cycles; the ID outputs show the same words one cycle later.
REQ-041 Ack at address 4 with if_stall_i=1 for 3 cycles -> the strobe drops, ID holds its previous value, and the word for address 4 appears the cycle after the stall releases.
REQ-042 take_branch_i with target 0x100 while the request at 0x8 waits 2 cycles -> the 0x8 response is discarded, ID shows NOP, and the next address is 0x100.
REQ-043 jump_i with target 0x102 -> no strobe, ID shows NOP_INSTR with id_exc_address_if_o=1; a later exc_trap_i with exc_pc_i=0x40 -> fetch resumes at 0x40.
REQ-044 iport_err_i at 0xC -> ID shows pc 0xC with id_exc_access_if_o=1; rst_i low mid-request -> the strobe drops at once and the PC reads RESET_ADDR.
